// File: rtl/arb_mux_rr.sv
// Round-robin N:1 arbiter and payload mux feeding a one-entry output register; packet lock when ARB_MUX_RR_LOCK_EN is defined.
// Latency: one cycle from an accepted input beat to out_valid; sustains one beat per cycle.
// Backpressure: in_ready is offered only when the output register is empty or being drained this cycle.
module arb_mux_rr #(
    parameter int num_port   = 4,
    parameter int data_width = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_port-1:0]            in_valid,
    output logic [num_port-1:0]            in_ready,
    input  logic [num_port*data_width-1:0] in_data,
`ifdef ARB_MUX_RR_LOCK_EN
    input  logic [num_port-1:0]            in_last,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_width-1:0]          out_data,
    output logic [num_port-1:0]            out_grant
);

    localparam int idx_w = (num_port > 1) ? $clog2(num_port) : 1;
    localparam logic [idx_w-1:0] last_rst = idx_w'(num_port - 1);

    logic                  out_valid_q, out_valid_d;
    logic [num_port-1:0]   out_grant_q, out_grant_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic [idx_w-1:0]      last_q, last_d;

    logic [num_port-1:0]   eligible;
    logic [num_port-1:0]   grant;
    logic [idx_w-1:0]      grant_idx;
    logic [idx_w-1:0]      cand_idx;
    logic [data_width-1:0] sel_data;
    logic                  load_en;
    logic                  xfer;

`ifdef ARB_MUX_RR_LOCK_EN
    logic lock_q, lock_d;

    // While a packet is open, the locked channel is the one recorded in last_q.
    always_comb begin
        eligible = in_valid;
        if (lock_q) begin
            eligible = in_valid & (num_port'(1) << last_q);
        end
    end
`else
    always_comb begin
        eligible = in_valid;
    end
`endif

    // Search begins one past the last granted channel and wraps.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int off = 1; off <= num_port; off++) begin
            cand_idx = idx_w'((int'(last_q) + off) % num_port);
            if ((grant == '0) && eligible[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < num_port; i++) begin
            sel_data = sel_data | (in_data[i*data_width +: data_width] & {data_width{grant[i]}});
        end
    end

    assign load_en  = ~out_valid_q | out_ready;
    assign in_ready = grant & {num_port{load_en & ~reset}};
    assign xfer     = |in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_grant_d = out_grant_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_grant_d = grant;
            out_data_d  = sel_data;
            last_d      = grant_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_grant_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_grant_q <= '0;
            out_data_q  <= '0;
            last_q      <= last_rst;
        end else begin
            out_valid_q <= out_valid_d;
            out_grant_q <= out_grant_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
        end
    end

`ifdef ARB_MUX_RR_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (xfer) begin
            lock_d = ~|(in_last & grant);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_grant = out_grant_q;
    assign out_data  = out_data_q;

endmodule
